// File: rtl/unidade_escrita_registradores_if.sv
// Bundle of the execute-side offer, the memory return path and the
// register-bank write port of the register writer.
// Offer handshake: an instruction result is taken on a posedge where
// entrada_valida and entrada_pronta are both 1; entrada_valida may be held
// across cycles, and entrada_pronta never depends on entrada_valida.
interface unidade_escrita_registradores_if #(
    parameter int LARGURA = 32
);
    logic               entrada_valida;
    logic               entrada_pronta;
    logic               regwrite_in;
    logic               regdst_in;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic               memtoreg;
    logic [LARGURA-1:0] resultado_alu;
    logic               memoria_valida;
    logic [LARGURA-1:0] dado_memoria;
    logic               regwrite;
    logic [4:0]         registrador_destino;
    logic [LARGURA-1:0] valorsalvar;
    logic [31:0]        ocupado;
    logic               vazio;
    logic               erro;

    // Producer side: execute stage and memory return path
    modport master (
        output entrada_valida, regwrite_in, regdst_in, rt, rd, memtoreg,
               resultado_alu, memoria_valida, dado_memoria,
        input  entrada_pronta, regwrite, registrador_destino, valorsalvar,
               ocupado, vazio, erro
    );

    // Register writer side
    modport slave (
        input  entrada_valida, regwrite_in, regdst_in, rt, rd, memtoreg,
               resultado_alu, memoria_valida, dado_memoria,
        output entrada_pronta, regwrite, registrador_destino, valorsalvar,
               ocupado, vazio, erro
    );
endinterface

// File: rtl/unidade_escrita_registradores.sv
// Register-file writer: in-order queue of completed instructions, in-order
// fill of pending loads from memory, one registered write per cycle, and a
// pending-write scoreboard (ocupado) for decode hazard detection.
module unidade_escrita_registradores #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 32
) (
    input logic clk,
    input logic reset,
    unidade_escrita_registradores_if.slave bus
);
    localparam int PW = $clog2(PROFUNDIDADE);

    // Queue storage; valida/pronto are reset, payload is not
    logic [4:0]              fila_dest [PROFUNDIDADE];
    logic [LARGURA-1:0]      fila_dado [PROFUNDIDADE];
    logic [PROFUNDIDADE-1:0] fila_valida;
    logic [PROFUNDIDADE-1:0] fila_pronto;
    logic [PW-1:0]           cabeca;
    logic [PW-1:0]           cauda;
    logic [PW:0]             contagem;

    // Registered write port and sticky error
    logic               regwrite_q;
    logic [4:0]         dest_q;
    logic [LARGURA-1:0] valor_q;
    logic               erro_q;

    // Decoded events for this edge
    logic          pronta;
    logic [4:0]    destino;
    logic          aceita;
    logic          empilha;
    logic          retira;
    logic          achou;
    logic [PW-1:0] preench;
    logic [PW-1:0] idx;

    assign pronta  = (contagem < (PW+1)'(PROFUNDIDADE));
    assign destino = bus.regdst_in ? bus.rd : bus.rt;
    assign aceita  = bus.entrada_valida & pronta;
    // Instructions without a real destination are consumed silently
    assign empilha = aceita & bus.regwrite_in & (destino != 5'd0);
    assign retira  = fila_valida[cabeca] & fila_pronto[cabeca];

    // Fill pointer: oldest valid entry still waiting for memory data
    always_comb begin
        achou   = 1'b0;
        preench = '0;
        idx     = '0;
        for (int k = 0; k < PROFUNDIDADE; k++) begin
            idx = cabeca + PW'(k);
            if (!achou && fila_valida[idx] && !fila_pronto[idx]) begin
                achou   = 1'b1;
                preench = idx;
            end
        end
    end

    // Control state: occupancy, pointers, flags, write port, error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cabeca      <= '0;
            cauda       <= '0;
            contagem    <= '0;
            fila_valida <= '0;
            fila_pronto <= '0;
            regwrite_q  <= 1'b0;
            dest_q      <= 5'd0;
            valor_q     <= '0;
            erro_q      <= 1'b0;
        end else begin
            if (retira) begin
                fila_valida[cabeca] <= 1'b0;
                cabeca              <= cabeca + PW'(1);
                regwrite_q          <= 1'b1;
                dest_q              <= fila_dest[cabeca];
                valor_q             <= fila_dado[cabeca];
            end else begin
                regwrite_q <= 1'b0;
            end
            if (bus.memoria_valida) begin
                if (achou) begin
                    fila_pronto[preench] <= 1'b1;
                end else begin
                    erro_q <= 1'b1;
                end
            end
            // The tail slot is never the head being popped nor the fill target
            if (empilha) begin
                fila_valida[cauda] <= 1'b1;
                fila_pronto[cauda] <= ~bus.memtoreg;
                cauda              <= cauda + PW'(1);
            end
            contagem <= contagem + {{PW{1'b0}}, empilha} - {{PW{1'b0}}, retira};
        end
    end

    // Payload: destination on push, data on push (ALU) or fill (load)
    always_ff @(posedge clk) begin
        if (bus.memoria_valida && achou) begin
            fila_dado[preench] <= bus.dado_memoria;
        end
        if (empilha) begin
            fila_dest[cauda] <= destino;
            if (!bus.memtoreg) begin
                fila_dado[cauda] <= bus.resultado_alu;
            end
        end
    end

    // Pending-write scoreboard over all valid entries
    always_comb begin
        bus.ocupado = 32'd0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            if (fila_valida[i]) begin
                bus.ocupado[fila_dest[i]] = 1'b1;
            end
        end
        bus.ocupado[0] = 1'b0;
    end

    assign bus.entrada_pronta      = pronta;
    assign bus.regwrite            = regwrite_q;
    assign bus.registrador_destino = dest_q;
    assign bus.valorsalvar         = valor_q;
    assign bus.vazio               = (contagem == '0) & ~regwrite_q;
    assign bus.erro                = erro_q;
endmodule

// File: tb/tb_unidade_escrita_registradores.sv
// Bench for the register writer: directed scenarios plus a randomized run
// compared cycle by cycle with a queue-based behavioural model.
module tb_unidade_escrita_registradores;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] dado;
        bit          pronto;
    } ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Behavioural model state
    ent_t        m_q[$];
    logic        m_rw;
    logic [4:0]  m_dest;
    logic [31:0] m_val;
    logic        m_erro;

    unidade_escrita_registradores_if #(.LARGURA(32)) bus ();

    unidade_escrita_registradores #(.PROFUNDIDADE(DEPTH), .LARGURA(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_ocupado();
        logic [31:0] o;
        o = 32'd0;
        foreach (m_q[i]) o[m_q[i].dest] = 1'b1;
        o[0] = 1'b0;
        return o;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_rw   = 1'b0;
        m_dest = 5'd0;
        m_val  = 32'd0;
        m_erro = 1'b0;
    endtask

    task automatic drive_idle();
        bus.entrada_valida = 1'b0;
        bus.regwrite_in    = 1'b0;
        bus.regdst_in      = 1'b0;
        bus.rt             = 5'd0;
        bus.rd             = 5'd0;
        bus.memtoreg       = 1'b0;
        bus.resultado_alu  = 32'd0;
        bus.memoria_valida = 1'b0;
        bus.dado_memoria   = 32'd0;
    endtask

    task automatic offer(input logic rw, input logic use_rd, input logic [4:0] f_rt,
                         input logic [4:0] f_rd, input logic mem, input logic [31:0] alu);
        bus.entrada_valida = 1'b1;
        bus.regwrite_in    = rw;
        bus.regdst_in      = use_rd;
        bus.rt             = f_rt;
        bus.rd             = f_rd;
        bus.memtoreg       = mem;
        bus.resultado_alu  = alu;
    endtask

    // One clock edge: model applies pop, fill and push from pre-edge state
    task automatic step();
        bit          acc;
        bit          pop;
        bit          mv;
        int          fi;
        logic [4:0]  d;
        logic [31:0] md;
        ent_t        e;
        acc = (bus.entrada_valida === 1'b1) && (m_q.size() < DEPTH)
              && (bus.regwrite_in === 1'b1);
        d   = bus.regdst_in ? bus.rd : bus.rt;
        e.dest   = d;
        e.dado   = bus.memtoreg ? 32'd0 : bus.resultado_alu;
        e.pronto = !bus.memtoreg;
        mv  = (bus.memoria_valida === 1'b1);
        md  = bus.dado_memoria;
        @(posedge clk);
        pop = (m_q.size() > 0) && m_q[0].pronto;
        if (mv) begin
            fi = -1;
            foreach (m_q[i]) if (fi < 0 && !m_q[i].pronto) fi = i;
            if (fi >= 0) begin
                m_q[fi].dado   = md;
                m_q[fi].pronto = 1'b1;
            end else begin
                m_erro = 1'b1;
            end
        end
        if (pop) begin
            ent_t h;
            h      = m_q.pop_front();
            m_rw   = 1'b1;
            m_dest = h.dest;
            m_val  = h.dado;
        end else begin
            m_rw = 1'b0;
        end
        if (acc && d != 5'd0) m_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({bus.regwrite, bus.registrador_destino, bus.valorsalvar, bus.erro} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs got rw=%b dest=%0d val=%h erro=%b exp all 0",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar, bus.erro);
        end
        total++;
        if (bus.ocupado !== 32'd0 || bus.entrada_pronta !== 1'b1 || bus.vazio !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags got ocup=%h pronta=%b vazio=%b exp 0/1/1",
                     bus.ocupado, bus.entrada_pronta, bus.vazio);
        end
    endtask

    task automatic test_alu_write();
        offer(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 32'h2A);
        step();
        drive_idle();
        total++;
        if (bus.ocupado !== 32'h20 || bus.regwrite !== 1'b0) begin
            bad++;
            $display("FAIL alu_after_n got ocup=%h rw=%b exp 00000020/0", bus.ocupado, bus.regwrite);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b1 || bus.registrador_destino !== 5'd5 || bus.valorsalvar !== 32'h2A) begin
            bad++;
            $display("FAIL alu_write got rw=%b dest=%0d val=%h exp 1/5/2a",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar);
        end
        total++;
        if (bus.ocupado !== 32'd0) begin
            bad++;
            $display("FAIL alu_ocup_clear got %h exp 0", bus.ocupado);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b0 || bus.vazio !== 1'b1 || bus.registrador_destino !== 5'd5) begin
            bad++;
            $display("FAIL alu_after got rw=%b vazio=%b dest=%0d exp 0/1/5",
                     bus.regwrite, bus.vazio, bus.registrador_destino);
        end
    endtask

    task automatic test_discard();
        offer(1'b0, 1'b1, 5'd0, 5'd7, 1'b0, 32'h55);
        step();
        drive_idle();
        total++;
        if (bus.ocupado !== 32'd0 || bus.vazio !== 1'b1) begin
            bad++;
            $display("FAIL discard_norw got ocup=%h vazio=%b exp 0/1", bus.ocupado, bus.vazio);
        end
        offer(1'b1, 1'b0, 5'd0, 5'd12, 1'b0, 32'h66);
        step();
        drive_idle();
        total++;
        if (bus.ocupado !== 32'd0 || bus.regwrite !== 1'b0) begin
            bad++;
            $display("FAIL discard_r0 got ocup=%h rw=%b exp 0/0", bus.ocupado, bus.regwrite);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b0 || bus.vazio !== 1'b1) begin
            bad++;
            $display("FAIL discard_nowrite got rw=%b vazio=%b exp 0/1", bus.regwrite, bus.vazio);
        end
    endtask

    task automatic test_load_stall();
        offer(1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 32'hDEAD);
        step();
        offer(1'b1, 1'b1, 5'd0, 5'd3, 1'b0, 32'h11);
        step();
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (bus.regwrite !== 1'b0 || bus.ocupado !== 32'h208) begin
                bad++;
                $display("FAIL stall_c%0d got rw=%b ocup=%h exp 0/00000208", c, bus.regwrite, bus.ocupado);
            end
        end
        bus.memoria_valida = 1'b1;
        bus.dado_memoria   = 32'h77;
        step();
        drive_idle();
        total++;
        if (bus.regwrite !== 1'b0) begin
            bad++;
            $display("FAIL stall_fill_edge got rw=%b exp 0", bus.regwrite);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b1 || bus.registrador_destino !== 5'd9 || bus.valorsalvar !== 32'h77) begin
            bad++;
            $display("FAIL stall_load_wr got rw=%b dest=%0d val=%h exp 1/9/77",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b1 || bus.registrador_destino !== 5'd3 || bus.valorsalvar !== 32'h11) begin
            bad++;
            $display("FAIL stall_alu_wr got rw=%b dest=%0d val=%h exp 1/3/11",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar);
        end
        step();
        total++;
        if (bus.regwrite !== 1'b0 || bus.vazio !== 1'b1 || bus.erro !== 1'b0) begin
            bad++;
            $display("FAIL stall_done got rw=%b vazio=%b erro=%b exp 0/1/0",
                     bus.regwrite, bus.vazio, bus.erro);
        end
    endtask

    task automatic test_spurious();
        bus.memoria_valida = 1'b1;
        bus.dado_memoria   = 32'hBAD;
        step();
        drive_idle();
        total++;
        if (bus.erro !== 1'b1 || bus.regwrite !== 1'b0) begin
            bad++;
            $display("FAIL spurious got erro=%b rw=%b exp 1/0", bus.erro, bus.regwrite);
        end
        repeat (2) step();
        total++;
        if (bus.erro !== 1'b1) begin
            bad++;
            $display("FAIL spurious_sticky got erro=%b exp 1", bus.erro);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 1'b0, 5'(i), 5'd0, 1'b1, 32'd0);
            step();
        end
        total++;
        if (bus.entrada_pronta !== 1'b0 || bus.ocupado !== 32'h1E) begin
            bad++;
            $display("FAIL full_flag got pronta=%b ocup=%h exp 0/0000001e", bus.entrada_pronta, bus.ocupado);
        end
        offer(1'b1, 1'b1, 5'd0, 5'd20, 1'b0, 32'hAB);
        step();
        drive_idle();
        total++;
        if (bus.ocupado[20] !== 1'b0 || bus.entrada_pronta !== 1'b0) begin
            bad++;
            $display("FAIL full_reject got ocup=%h pronta=%b exp bit20=0/0", bus.ocupado, bus.entrada_pronta);
        end
        bus.memoria_valida = 1'b1;
        bus.dado_memoria   = 32'h100;
        step();
        drive_idle();
        step();
        total++;
        if (bus.regwrite !== 1'b1 || bus.registrador_destino !== 5'd1 || bus.valorsalvar !== 32'h100
            || bus.entrada_pronta !== 1'b1) begin
            bad++;
            $display("FAIL full_pop got rw=%b dest=%0d val=%h pronta=%b exp 1/1/100/1",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar, bus.entrada_pronta);
        end
    endtask

    task automatic test_reset_mid();
        // Three loads (rt 2..4) remain queued from the full-queue scenario
        total++;
        if (bus.ocupado !== 32'h1C) begin
            bad++;
            $display("FAIL mid_pending got ocup=%h exp 0000001c", bus.ocupado);
        end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        total++;
        if (bus.regwrite !== 1'b0 || bus.registrador_destino !== 5'd0 || bus.valorsalvar !== 32'd0
            || bus.ocupado !== 32'd0 || bus.vazio !== 1'b1) begin
            bad++;
            $display("FAIL mid_async got rw=%b dest=%0d val=%h ocup=%h vazio=%b exp 0/0/0/0/1",
                     bus.regwrite, bus.registrador_destino, bus.valorsalvar, bus.ocupado, bus.vazio);
        end
        #1;
        reset = 1'b0;
        repeat (3) step();
        total++;
        if (bus.regwrite !== 1'b0 || bus.ocupado !== 32'd0 || bus.erro !== 1'b0) begin
            bad++;
            $display("FAIL mid_after got rw=%b ocup=%h erro=%b exp 0/0/0", bus.regwrite, bus.ocupado, bus.erro);
        end
        bus.memoria_valida = 1'b1;
        bus.dado_memoria   = 32'h5;
        step();
        drive_idle();
        total++;
        if (bus.erro !== 1'b1 || bus.regwrite !== 1'b0) begin
            bad++;
            $display("FAIL mid_late_data got erro=%b rw=%b exp 1/0", bus.erro, bus.regwrite);
        end
    endtask

    task automatic test_random();
        bit waiting;
        test_reset();
        for (int c = 0; c < 400; c++) begin
            waiting = 1'b0;
            foreach (m_q[i]) if (!m_q[i].pronto) waiting = 1'b1;
            bus.entrada_valida = ($urandom_range(0, 2) != 0);
            bus.regwrite_in    = ($urandom_range(0, 7) != 0);
            bus.regdst_in      = 1'($urandom_range(0, 1));
            bus.rt             = 5'($urandom_range(0, 31));
            bus.rd             = 5'($urandom_range(0, 31));
            bus.memtoreg       = ($urandom_range(0, 2) == 0);
            bus.resultado_alu  = $urandom;
            bus.memoria_valida = waiting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            bus.dado_memoria   = $urandom;
            step();
            total++;
            if (bus.regwrite !== m_rw || bus.registrador_destino !== m_dest || bus.valorsalvar !== m_val) begin
                bad++;
                $display("FAIL rnd_write c=%0d got rw=%b dest=%0d val=%h exp %b/%0d/%h",
                         c, bus.regwrite, bus.registrador_destino, bus.valorsalvar, m_rw, m_dest, m_val);
            end
            total++;
            if (bus.ocupado !== model_ocupado()) begin
                bad++;
                $display("FAIL rnd_ocupado c=%0d got %h exp %h", c, bus.ocupado, model_ocupado());
            end
            total++;
            if (bus.entrada_pronta !== (m_q.size() < DEPTH) || bus.vazio !== (m_q.size() == 0 && !m_rw)
                || bus.erro !== m_erro) begin
                bad++;
                $display("FAIL rnd_flags c=%0d got pronta=%b vazio=%b erro=%b exp %b/%b/%b", c,
                         bus.entrada_pronta, bus.vazio, bus.erro,
                         (m_q.size() < DEPTH), (m_q.size() == 0 && !m_rw), m_erro);
            end
        end
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        test_reset();
        test_alu_write();
        test_discard();
        test_load_stall();
        test_spurious();
        test_reset();
        test_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/unidade_escrita_registradores.md
Name: unidade_escrita_registradores

Overview:
- Writer side of the register-file write port: drives regwrite, the destination register and valorsalvar into the register bank.
- Accepts completed instructions from the execute stage and buffers them in an in-order queue.
- Loads are enqueued before their memory data arrives and are filled in order when the data returns.
- Publishes a pending-write scoreboard (ocupado) for hazard detection in decode.

Parameters:
PROFUNDIDADE, 4, queue entries; power of 2, minimum 2
LARGURA, 32, data width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
entrada_valida  input  1  execute stage offers one instruction result
entrada_pronta  output  1  queue can accept; equals (contagem < PROFUNDIDADE)
regwrite_in  input  1  instruction writes a register
regdst_in  input  1  1 = destination is rd, 0 = destination is rt
rt  input  5  rt field
rd  input  5  rd field
memtoreg  input  1  value comes from memory (load)
resultado_alu  input  LARGURA  ALU result
memoria_valida  input  1  load data returning this cycle
dado_memoria  input  LARGURA  returned load data
regwrite  output  1  write strobe to the register bank, one cycle per write
registrador_destino  output  5  destination register number
valorsalvar  output  LARGURA  value to write
ocupado  output  32  bit i = 1 while a queued write targets register i; bit 0 is always 0
vazio  output  1  queue empty and regwrite = 0
erro  output  1  sticky: memory data arrived with no load waiting

Behaviour:
- Reset (asynchronous, active-high): regwrite = 0, registrador_destino = 0, valorsalvar = 0, erro = 0, queue empty, ocupado = 0, entrada_pronta = 1, vazio = 1. Asserting reset mid-operation discards all pending entries and any outstanding load; memory data that arrives later with no waiting load sets erro.
- Accept condition: entrada_valida & entrada_pronta at the posedge.
  - Destination = regdst_in ? rd : rt.
  - If regwrite_in = 0 or destination = 0: the instruction is consumed and no entry is created.
  - Otherwise an entry {dest, dado, pronto} is pushed at the tail:
    - memtoreg = 0: dado = resultado_alu, pronto = 1.
    - memtoreg = 1: pronto = 0 (waiting for memory data).
- Load fill:
  - A fill pointer tracks the oldest entry with pronto = 0.
  - At a posedge with memoria_valida = 1, that entry takes dado = dado_memoria and pronto = 1.
  - Only entries already valid before the edge are eligible; data cannot fill a load accepted on the same edge.
  - If no entry is waiting, the data is dropped and erro is set until reset.
- Issue (registered):
  - At each posedge, if the head entry has pronto = 1: regwrite <= 1, registrador_destino <= dest, valorsalvar <= dado, and the head is popped.
  - Otherwise regwrite <= 0 and registrador_destino / valorsalvar hold their previous values.
  - At most one write per cycle. Writes issue strictly in program order; a waiting load at the head stalls everything behind it.
- Latency:
  - ALU entry accepted at edge N into an empty queue: regwrite = 1 after edge N+1, and the bank captures it at edge N+2.
  - Load data filled at edge M with the entry at the head: issued at edge M+1.
- Full / simultaneous events:
  - entrada_pronta depends only on occupancy, so there is no accept-while-full even when a pop happens on the same edge.
  - Push, fill and pop on the same edge are all legal; contagem changes by (push − pop).
  - Pointers wrap modulo PROFUNDIDADE.
- ocupado: combinational OR of one-hot(dest) over all valid entries. A bit stays set while any remaining entry targets that register. It clears on the edge where the last such entry is popped (the write is still on the regwrite outputs for that cycle).

Test Plan:
- ALU write: reset, then offer regdst_in=1, rd=5, regwrite_in=1, resultado_alu=0x2A -> ocupado[5]=1 after edge N; after edge N+1, regwrite=1, registrador_destino=5, valorsalvar=0x2A for one cycle; vazio=1 afterwards.
- Discard cases: regwrite_in=0, and separately regdst_in=0 with rt=0 -> no queue entry, regwrite stays 0, ocupado stays 0.
- Load stall: push load to rt=9 (regdst_in=0), then ALU write 0x11 to rd=3; memoria_valida with 0x77 arrives 3 cycles later -> no write until the fill; then consecutive writes (9, 0x77) then (3, 0x11); ocupado = bits 9|3 during the stall.
- Full queue: push 4 load entries -> entrada_pronta=0; a fifth offer is not accepted; after one fill and one pop, entrada_pronta returns to 1.
- Spurious memory data: memoria_valida=1 with the queue empty -> erro=1 and stays 1; no regwrite.
- Reset mid-operation: 3 entries pending, reset pulsed asynchronously between edges -> all outputs 0 immediately, no further writes, ocupado=0.
